// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller pipeline-status inputs and control outputs
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_src1;
  logic [4:0]  id_src2;
  logic        id_two_src;
  logic [4:0]  exe_dest;
  logic        exe_wb_en;
  logic        exe_mem_r_en;
  logic [4:0]  mem_dest;
  logic        mem_wb_en;
  logic        fwd_en;
  logic        br_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_hold;
  logic        ifid_hold;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        pipe_hold;
  logic        err;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, fwd_en, br_taken, mem_req, mem_ready,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_hold, err,
           state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, fwd_en, br_taken, mem_req, mem_ready,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_hold, err,
           state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush/hold control with memory watchdog and perf counters
module pipe_hazard_ctrl (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  logic [1:0]  state_q;
  logic [7:0]  wait_cnt;
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  logic raw_exe;
  logic raw_mem;
  logic hazard;
  logic mwait;
  logic hold;
  logic do_flush;
  logic do_stall;

  always_comb begin
    raw_exe  = (bus.exe_dest != 5'd0) &&
               ((bus.exe_dest == bus.id_src1) || (bus.id_two_src && (bus.exe_dest == bus.id_src2)));
    raw_mem  = (bus.mem_dest != 5'd0) &&
               ((bus.mem_dest == bus.id_src1) || (bus.id_two_src && (bus.mem_dest == bus.id_src2)));
    hazard   = (raw_exe && bus.exe_mem_r_en) ||
               (!bus.fwd_en && ((raw_exe && bus.exe_wb_en) || (raw_mem && bus.mem_wb_en)));
    mwait    = bus.mem_req && !bus.mem_ready;
    // A hold swallows any branch or hazard; a taken branch discards a coincident hazard.
    hold     = (state_q == ST_ERROR) || mwait;
    do_flush = !hold && bus.br_taken;
    do_stall = !hold && !bus.br_taken && hazard;
  end

  assign bus.pipe_hold   = rst && hold;
  assign bus.pc_hold     = rst && (hold || do_stall);
  assign bus.ifid_hold   = rst && (hold || do_stall);
  assign bus.ifid_flush  = rst && do_flush;
  assign bus.idex_bubble = rst && (do_flush || do_stall);
  assign bus.err         = (state_q == ST_ERROR);
  assign bus.state       = state_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      if (do_stall && (stall_q != 16'hFFFF))
        stall_q <= stall_q + 16'd1;
      if (do_flush && (flush_q != 16'hFFFF))
        flush_q <= flush_q + 16'd1;
    end
  end

  // wait_cnt counts memory-wait cycles already spent; the 256th consecutive one trips ERROR.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      wait_cnt <= 8'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mwait) begin
            state_q  <= ST_MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (!mwait) begin
            state_q  <= ST_RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == 8'd255) begin
            state_q  <= ST_ERROR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_ERROR: begin
          state_q <= ST_ERROR;
        end
        default: begin
          state_q  <= ST_RUN;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports (name  direction  width  meaning), one clock, synchronous active-low reset:
- clk  in  1  sole clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- id_src1, id_src2  in  5 each  source register numbers of instruction in ID.
- id_two_src  in  1  ID instruction reads id_src2.
- exe_dest  in  5  dest of instruction in EXE.
- exe_wb_en, exe_mem_r_en  in  1 each  EXE instruction writes back / is a load.
- mem_dest  in  5  dest of instruction in MEM.
- mem_wb_en  in  1  MEM instruction writes back.
- fwd_en  in  1  forwarding unit active.
- br_taken  in  1  branch resolved taken in EXE.
- mem_req, mem_ready  in  1 each  MEM-stage data-memory access pending / completed.
- pc_hold  out  1  PC keeps value.
- ifid_hold  out  1  IF/ID register keeps value.
- ifid_flush  out  1  IF/ID loads NOP.
- idex_bubble  out  1  ID/EXE loads NOP (all control bits 0).
- pipe_hold  out  1  every pipeline register and PC keep value.
- err  out  1  memory watchdog expired (sticky).
- state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERROR.
- stall_cnt, flush_cnt  out  16 each  performance counters.

Function
REQ-002 SHALL derive control outputs combinationally from current state and inputs; state, wait counter and perf counters are registered.
REQ-003 SHALL define raw_exe = exe_dest!=0 and (exe_dest==id_src1 or (id_two_src and exe_dest==id_src2)); raw_mem likewise with mem_dest.
REQ-004 SHALL define hazard = (raw_exe and exe_mem_r_en) or (!fwd_en and ((raw_exe and exe_wb_en) or (raw_mem and mem_wb_en))).
REQ-005 SHALL define mwait = mem_req and !mem_ready.
REQ-006 Priority, highest first: ERROR state > mwait > br_taken > hazard > none.
REQ-007 ERROR or mwait: pipe_hold=1, pc_hold=1, ifid_hold=1; ifid_flush=0, idex_bubble=0; br_taken and hazard ignored this cycle.
REQ-008 br_taken (no hold): ifid_flush=1, idex_bubble=1, pc_hold=0, ifid_hold=0; coincident hazard discarded.
REQ-009 hazard (no hold, no branch): pc_hold=1, ifid_hold=1, idex_bubble=1, ifid_flush=0.
REQ-010 None: all control outputs 0.
REQ-011 FSM RUN: mwait -> MEM_WAIT, wait counter := 1; else stay.
REQ-012 FSM MEM_WAIT: !mwait -> RUN, wait counter := 0; mwait and wait counter==255 -> ERROR; else wait counter +1 (8-bit).
REQ-013 FSM ERROR: terminal until reset; err=1 only in ERROR.
REQ-014 stall_cnt SHALL +1 on each cycle REQ-009 applies; flush_cnt +1 on each cycle REQ-008 applies; both saturate at 16'hFFFF.
REQ-015 Latency: hazard/branch/mwait response in same cycle as input; state change visible next cycle.
REQ-016 mwait deasserting in MEM_WAIT releases pipe_hold same cycle (combinational), state RUN next cycle.

Reset
REQ-017 rst=0 at rising edge: state=RUN, wait counter=0, stall_cnt=0, flush_cnt=0, err=0, regardless of state (including ERROR or mid-MEM_WAIT).
REQ-018 While rst=0, pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_hold SHALL be forced 0.

Verification
REQ-019 Load-use: exe_mem_r_en=1, exe_dest=5, id_src1=5, fwd_en=1 one cycle -> pc_hold=ifid_hold=idex_bubble=1 that cycle, stall_cnt 0->1.
REQ-020 R0 / forwarding: exe_dest=0 load with id_src1=0 -> no stall; fwd_en=0, mem_wb_en=1, mem_dest=7, id_two_src=1, id_src2=7 -> stall.
REQ-021 Branch+hazard same cycle: br_taken=1 and load-use -> ifid_flush=idex_bubble=1, pc_hold=0, flush_cnt+1, stall_cnt unchanged.
REQ-022 Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> pipe_hold=1 for 3 cycles, state=1 cycles 2-4, RUN after; branch during wait ignored.
REQ-023 Watchdog: mwait held 300 cycles -> state=ERROR, err=1 after 256th wait cycle, pipe_hold stays 1 after mem_ready=1; rst=0 one edge -> state=0, err=0, counters 0.
REQ-024 Saturation: 70000 consecutive hazard cycles -> stall_cnt=16'hFFFF, no wrap.
